// File: rtl/level_hv_bundler_pkg.sv
// Shared types and level helpers for the level-to-hypervector bundler.
// Combinational only: no latency.
// No flow control here.
package hdc_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam int          NUM_LEVELS = 10;
    localparam logic [3:0]  MAX_LEVEL  = 4'd9;

    // Codes above the last real level come from quantizer overflow; pin them to the top level
    function automatic logic [3:0] clamp_level(input logic [3:0] lvl);
        return (lvl >= 4'(NUM_LEVELS)) ? MAX_LEVEL : lvl;
    endfunction

endpackage

// File: rtl/level_hv_bundler_segment_wta.sv
// One segment: SEG_LEN saturating histogram counters plus the winner-take-all scan registers.
// Counter increments visible next cycle; win_idx_o is the combinational next best index.
// No backpressure: the parent sequences inc/clear/scan.
module segment_wta
    import hdc_pkg::*;
#(
    parameter int SEG_LEN = 16,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             inc_en,
    input  logic [IDX_W-1:0] inc_idx,
    input  logic             clear,
    input  logic             scan_en,
    input  logic [IDX_W-1:0] scan_j,
    output logic [IDX_W-1:0] win_idx_o
);

    logic [CNT_W-1:0] cnt_q [SEG_LEN];
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [CNT_W-1:0] cur_cnt;
    logic             take;

    // Histogram counters: cleared on reset/handshake, saturating increment otherwise
    always_ff @(posedge clk) begin
        if (!nrst || clear) begin
            for (int i = 0; i < SEG_LEN; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (inc_en && (cnt_q[inc_idx] != '1)) begin
            cnt_q[inc_idx] <= cnt_q[inc_idx] + CNT_W'(1);
        end
    end

    // Scan step: position 0 always seeds the best; strict > keeps the lowest index on ties
    always_comb begin
        cur_cnt    = cnt_q[scan_j];
        take       = (scan_j == '0) || (cur_cnt > best_cnt_q);
        best_cnt_d = best_cnt_q;
        best_idx_d = best_idx_q;
        if (scan_en && take) begin
            best_cnt_d = cur_cnt;
            best_idx_d = scan_j;
        end
    end

    // Best-so-far registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            best_cnt_q <= '0;
            best_idx_q <= '0;
        end else begin
            best_cnt_q <= best_cnt_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign win_idx_o = best_idx_d;

endmodule

// File: rtl/level_hv_bundler.sv
// Bundles a stream of quantized levels into one sparse segmented hypervector per sample.
// HV valid SEG_LEN+1 cycles after the in_last beat is accepted; one beat per cycle in ACCUM.
// in_ready low during SCAN/OUT; hv_index held while hv_valid && !hv_ready. Optional macro: LEVEL_BUNDLER_LEN_CHECK_EN.
module level_hv_bundler
    import hdc_pkg::*;
#(
    parameter int SEGMENTS     = 8,
    parameter int SEG_LEN      = 16,
    parameter int IDX_W        = 4,
    parameter int CNT_W        = 6,
    parameter int FEAT_W       = 10,
    parameter int LEVEL_STEP   = 1,
    parameter int BASE_MUL     = 3
`ifdef LEVEL_BUNDLER_LEN_CHECK_EN
    ,
    parameter int NUM_FEATURES = 617
`endif
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_level,
    input  logic                      in_last,
    output logic                      hv_valid,
    input  logic                      hv_ready,
    output logic [SEGMENTS*IDX_W-1:0] hv_index
`ifdef LEVEL_BUNDLER_LEN_CHECK_EN
    ,
    output logic                      len_err
`endif
);

    state_t                    state_q, state_d;
    logic [FEAT_W-1:0]         feat_q;
    logic [IDX_W-1:0]          scan_j_q;
    logic [SEGMENTS*IDX_W-1:0] hv_index_q;
    logic [SEGMENTS*IDX_W-1:0] win_all;
    logic [IDX_W-1:0]          lvl_ofs;
    logic                      accept;
    logic                      hv_done;
    logic                      scan_last;

    assign accept    = in_valid && in_ready;
    assign hv_done   = hv_valid && hv_ready;
    assign scan_last = (state_q == SCAN) && (scan_j_q == '1);
    assign lvl_ofs   = IDX_W'(32'(clamp_level(in_level)) * LEVEL_STEP);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: the in_last beat is counted before the scan begins
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && in_last) state_d = SCAN;
            SCAN:    if (scan_j_q == '1)    state_d = OUT;
            OUT:     if (hv_ready)          state_d = ACCUM;
            default:                        state_d = ACCUM;
        endcase
    end

    // FSM outputs: in_ready is gated by reset so nothing is taken while held in reset
    always_comb begin
        in_ready = nrst && (state_q == ACCUM);
        hv_valid = (state_q == OUT);
    end

    // Feature counter (saturating), scan position and output register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            feat_q     <= '0;
            scan_j_q   <= '0;
            hv_index_q <= '0;
        end else begin
            if (hv_done) begin
                feat_q <= '0;
            end else if (accept && (feat_q != '1)) begin
                feat_q <= feat_q + FEAT_W'(1);
            end
            scan_j_q <= (state_q == SCAN) ? scan_j_q + IDX_W'(1) : '0;
            if (scan_last) begin
                hv_index_q <= win_all;
            end
        end
    end

    assign hv_index = hv_index_q;

    // Per-segment binding: base offset, level offset and feature-position rotation
    for (genvar s = 0; s < SEGMENTS; s++) begin : g_seg
        localparam logic [IDX_W-1:0] BASE_OFS = IDX_W'(BASE_MUL * s);
        logic [IDX_W-1:0] seg_idx;

        assign seg_idx = BASE_OFS + lvl_ofs + feat_q[IDX_W-1:0];

        segment_wta #(
            .SEG_LEN (SEG_LEN),
            .IDX_W   (IDX_W),
            .CNT_W   (CNT_W)
        ) u_wta (
            .clk       (clk),
            .nrst      (nrst),
            .inc_en    (accept),
            .inc_idx   (seg_idx),
            .clear     (hv_done),
            .scan_en   (state_q == SCAN),
            .scan_j    (scan_j_q),
            .win_idx_o (win_all[s*IDX_W +: IDX_W])
        );
    end

`ifdef LEVEL_BUNDLER_LEN_CHECK_EN
    logic len_err_q;

    // Sample-length check, evaluated when the closing beat is accepted
    always_ff @(posedge clk) begin
        if (!nrst) begin
            len_err_q <= 1'b0;
        end else if (accept && in_last) begin
            len_err_q <= (({1'b0, feat_q} + (FEAT_W+1)'(1)) != (FEAT_W+1)'(NUM_FEATURES));
        end
    end

    assign len_err = len_err_q;
`endif

endmodule

// File: tb/tb_level_hv_bundler.sv
module tb_level_hv_bundler;

    logic        clk = 1'b0;
    logic        nrst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_level;
    logic        in_last;
    logic        hv_valid;
    logic        hv_ready;
    logic [31:0] hv_index;
`ifdef LEVEL_BUNDLER_LEN_CHECK_EN
    logic        len_err;
`endif

    always #5 clk = ~clk;

    level_hv_bundler dut (
        .clk      (clk),
        .nrst     (nrst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_level (in_level),
        .in_last  (in_last),
        .hv_valid (hv_valid),
        .hv_ready (hv_ready),
        .hv_index (hv_index)
`ifdef LEVEL_BUNDLER_LEN_CHECK_EN
        ,
        .len_err  (len_err)
`endif
    );

    int n_run  = 0;
    int n_fail = 0;

    // Reference model: plain per-segment histograms and a feature count
    int hist [8][16];
    int mf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 8; s++)
            for (int j = 0; j < 16; j++)
                hist[s][j] = 0;
        mf = 0;
    endtask

    task automatic model_accept(input logic [3:0] lvl);
        int l;
        int idx;
        l = (int'(lvl) > 9) ? 9 : int'(lvl);
        for (int s = 0; s < 8; s++) begin
            idx = (3 * s + l + mf) % 16;
            if (hist[s][idx] < 63) hist[s][idx]++;
        end
        if (mf < 1023) mf++;
    endtask

    // Winner per segment: highest count, lowest index among equals
    function automatic logic [31:0] model_hv();
        logic [31:0] r;
        int best;
        r = '0;
        for (int s = 0; s < 8; s++) begin
            best = 0;
            for (int j = 1; j < 16; j++)
                if (hist[s][j] > hist[s][best]) best = j;
            r[s*4 +: 4] = 4'(best);
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_beat(input logic [3:0] lvl, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_level = lvl;
        in_last  = last;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("beat_accept_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_accept(lvl);
    endtask

    // lat counts edges from the in_last acceptance edge to the first hv_valid
    task automatic wait_hv(output int lat);
        lat = 1;
        while (!hv_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!hv_valid) chk("hv_valid_timeout", 32'(hv_valid), 32'd1);
    endtask

    task automatic take_hv(input string name, input logic [31:0] exp, input int hold);
        chk({name, "_valid"}, 32'(hv_valid), 32'd1);
        chk({name, "_index"}, hv_index, exp);
        hv_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, 32'(hv_valid), 32'd1);
            chk({name, "_hold_index"}, hv_index, exp);
            chk({name, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        hv_ready = 1'b1;
        @(negedge clk);
        hv_ready = 1'b0;
        chk({name, "_post_valid"}, 32'(hv_valid), 32'd0);
        chk({name, "_post_rdy"}, 32'(in_ready), 32'd1);
        chk({name, "_post_index"}, hv_index, exp);
        model_clear();
    endtask

    typedef struct {
        int          n;
        logic [3:0]  lv [4];
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (tests %0d)", n_run);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int len;
        logic [31:0] exp;

        nrst = 1'b0; in_valid = 1'b0; in_level = '0; in_last = 1'b0; hv_ready = 1'b0;
        model_clear();

        tbl[0].n = 1; tbl[0].lv = '{4'd0, 4'd0, 4'd0, 4'd0}; tbl[0].exp = 32'h52FC9630;
        tbl[1].n = 2; tbl[1].lv = '{4'd2, 4'd1, 4'd0, 4'd0}; tbl[1].exp = 32'h741EB852;
        tbl[2].n = 2; tbl[2].lv = '{4'd0, 4'd0, 4'd0, 4'd0}; tbl[2].exp = 32'h520C9630;
        tbl[3].n = 1; tbl[3].lv = '{4'hF, 4'd0, 4'd0, 4'd0}; tbl[3].exp = 32'hEB852FC9;

        // Reset behaviour
        @(negedge clk);
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_hv_valid", 32'(hv_valid), 32'd0);
        chk("rst_hv_index", hv_index, 32'd0);
`ifdef LEVEL_BUNDLER_LEN_CHECK_EN
        chk("rst_len_err", 32'(len_err), 32'd0);
`endif
        @(negedge clk);

        // Directed vectors
        for (int v = 0; v < 4; v++) begin
            for (int b = 0; b < tbl[v].n; b++)
                send_beat(tbl[v].lv[b], (b == tbl[v].n - 1));
            wait_hv(lat);
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd17);
            chk($sformatf("vec%0d_model", v), model_hv(), tbl[v].exp);
            take_hv($sformatf("vec%0d", v), tbl[v].exp, 0);
            @(negedge clk);
        end

        // Backpressure hold in OUT, then a fresh sample from zeroed counters
        send_beat(4'd5, 1'b0);
        send_beat(4'd7, 1'b1);
        wait_hv(lat);
        take_hv("hold", model_hv(), 5);
        send_beat(4'd0, 1'b1);
        wait_hv(lat);
        take_hv("after_hold", 32'h52FC9630, 0);

        // Reset in the middle of the scan discards the sample
        send_beat(4'd3, 1'b0);
        send_beat(4'd3, 1'b1);
        repeat (5) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("midscan_hv_valid", 32'(hv_valid), 32'd0);
        chk("midscan_in_ready", 32'(in_ready), 32'd1);
        model_clear();
        @(negedge clk);
        send_beat(4'd0, 1'b1);
        wait_hv(lat);
        chk("midscan_latency", 32'(lat), 32'd17);
        take_hv("midscan_next", 32'h52FC9630, 0);

        // Counter saturation: steer every beat at the same position when possible
        for (int b = 0; b < 110; b++) begin
            len = (9 - mf) & 15;
            send_beat((len <= 9) ? 4'(len) : 4'd0, (b == 109));
        end
        wait_hv(lat);
        take_hv("saturate", model_hv(), 1);

        // Randomized samples against the model
        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(1, 40);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                send_beat(4'($urandom_range(0, 15)), (b == len - 1));
            end
            wait_hv(lat);
            chk($sformatf("rand%0d_latency", t), 32'(lat), 32'd17);
            exp = model_hv();
            take_hv($sformatf("rand%0d", t), exp, $urandom_range(0, 3));
        end

`ifdef LEVEL_BUNDLER_LEN_CHECK_EN
        // Length check: short sample flags, exact-length sample clears
        for (int b = 0; b < 3; b++) send_beat(4'd4, (b == 2));
        chk("len_short", 32'(len_err), 32'd1);
        wait_hv(lat);
        take_hv("len_short_hv", model_hv(), 0);
        for (int b = 0; b < 617; b++) send_beat(4'($urandom_range(0, 9)), (b == 616));
        chk("len_exact", 32'(len_err), 32'd0);
        wait_hv(lat);
        take_hv("len_exact_hv", model_hv(), 0);
        chk("len_hold", 32'(len_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/level_hv_bundler.md
Name: level_hv_bundler

Overview:
- Downstream consumer of the 4-bit quantized level stream (levels 0..9, one per feature) from the float quantizer.
- Per feature: derives the sparse level hypervector (one active index per segment), binds it to the feature position by cyclic in-segment shift, and accumulates per-segment histograms.
- At end of sample: runs a sequential winner-take-all scan and emits one sparse sample hypervector to the HDC similarity/classifier stage.

Parameters:
- SEGMENTS, 8, number of segments in the sparse HV.
- SEG_LEN, 16, positions per segment; power of 2.
- IDX_W, 4, log2(SEG_LEN).
- CNT_W, 6, per-position histogram counter width.
- FEAT_W, 10, feature counter width.
- LEVEL_STEP, 1, index advance per quantization level.
- BASE_MUL, 3, per-segment base index multiplier.
- NUM_FEATURES, 617, expected features per sample (used only under the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- nrst  in  1  reset, synchronous, active-low.
- in_valid  in  1  level beat valid.
- in_ready  out  1  block accepts a beat.
- in_level  in  4  quantized level; values 10..15 are treated as 9.
- in_last  in  1  marks the final feature of the sample.
- hv_valid  out  1  sample HV available.
- hv_ready  in  1  downstream accepts the HV.
- hv_index  out  SEGMENTS*IDX_W  winning index per segment; segment 0 occupies bits [IDX_W-1:0].
- len_err  out  1  present only with LEVEL_BUNDLER_LEN_CHECK_EN.

Behaviour:
- Reset: nrst sampled low at a rising edge sets:
  - state=ACCUM, all counters=0, feature count=0, scan index=0, best regs=0;
  - hv_valid=0, hv_index=0, len_err=0.
  - in_ready is forced 0 while nrst=0. Reset mid-scan or mid-output discards the partial sample.
- States:
  - ACCUM: in_ready=1. Beat accepted when in_valid&&in_ready.
  - SCAN: in_ready=0. Lasts exactly SEG_LEN cycles.
  - OUT: in_ready=0, hv_valid=1.
- Index math on an accepted beat with level L (clamped to 9) and feature count f:
  - idx[s] = (BASE_MUL*s + L*LEVEL_STEP + f) mod SEG_LEN; mod is a truncation to IDX_W bits.
  - counter[s][idx[s]] increments, saturating at 2^CNT_W-1.
  - f increments, saturating at all-ones.
  - Updates become visible the next cycle.
- Scan start: accepting an in_last beat at cycle T counts that beat, then moves to SCAN at T+1.
- SCAN, cycle j=0..SEG_LEN-1, in all segments in parallel: if j==0 or counter[s][j] > best_cnt[s], then best_cnt[s]=counter[s][j] and best_idx[s]=j. Strict greater-than means ties resolve to the lowest index.
- Output: after j=SEG_LEN-1, hv_index<=best_idx and state=OUT.
  - hv_valid is first high in cycle T+1+SEG_LEN.
  - hv_index holds stable while hv_valid&&!hv_ready.
- Handshake: on hv_valid&&hv_ready:
  - all counters and f clear in that same edge; hv_valid drops; state returns to ACCUM.
  - in_ready is high the next cycle.
  - hv_index keeps its last value.
- A sample always contains at least one beat, because the in_last beat itself is counted.
- in_valid while not ready: the source must hold the beat; the block does not consume it.

Optional Feature:
- Macro: LEVEL_BUNDLER_LEN_CHECK_EN.
- Enabled:
  - len_err port exists.
  - On acceptance of the in_last beat, len_err<=1 if (f+1)!=NUM_FEATURES, else 0.
  - len_err holds until the next in_last acceptance or reset.
  - The HV is still produced normally.
- Disabled: no port, no comparator; behaviour otherwise identical.

Decomposition:
- Package hdc_pkg:
  - state enum {ACCUM, SCAN, OUT};
  - NUM_LEVELS=10, MAX_LEVEL=4'd9;
  - the level-clamp function.
- Sub-module segment_wta, instantiated SEGMENTS times:
  - holds one segment's SEG_LEN counters and the best_cnt/best_idx scan registers;
  - inputs: inc_en, inc_idx, clear, scan_en, scan_j.
- Top level holds the FSM, feature counter, index math and output register.

Test Plan (defaults):
- Reset, then one beat (level 0, in_last=1) at cycle T:
  - hv_valid rises at T+17;
  - hv_index segments 0..7 = {0,3,6,9,12,15,2,5}.
- Beat f0 level 2 followed by beat f1 level 1 with in_last:
  - both map to base+2, so each segment's count is 2;
  - hv_index = {2,5,8,11,14,1,4,7}.
- Tie case, f0 level 0 then f1 level 0 with in_last:
  - expect {0,3,6,9,12,0,2,5}; segment 5 tie between 15 and 0 resolves to 0.
- Hold hv_ready=0 for 5 cycles in OUT:
  - hv_valid stays 1, hv_index stable, in_ready=0;
  - on release, in_ready=1 the next cycle and the next sample starts from zeroed counters.
- Level input 4'hF on a single in_last beat: result identical to level 9, i.e. {9,12,15,2,5,8,11,14}.
- Deassert nrst mid-SCAN:
  - next cycle: hv_valid=0, in_ready=1;
  - the following single level-0 sample yields {0,3,6,9,12,15,2,5}.
- With LEVEL_BUNDLER_LEN_CHECK_EN: 3-beat sample gives len_err=1; a full 617-beat sample gives len_err=0.
